ex_mem_stage_skid: RTL

Parametrised, elastic successor to the fixed EX/MEM pipeline register. It sits between execute and memory and carries `NDATA` XLEN-wide data lanes plus a `CTRL_W`-bit control bundle. A valid/ready handshake with a 2-entry skid buffer replaces the bare clock enable, so memory-side back-pressure never creates a combinational path back to execute. It adds explicit flush, exception squash, and an occupancy readout.

---
 rtl/ex_mem_stage_skid_if.sv | 42 ++++
 rtl/ex_mem_stage_skid.sv | 116 +++++++++++
 2 files changed

// File: rtl/ex_mem_stage_skid_if.sv
// ============================================================================
//  Module   : ex_mem_stage_skid_if
//  Purpose  : Execute-to-memory handshake bundle for the elastic EX/MEM stage.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

interface ex_mem_stage_skid_if #(
    parameter int XLEN   = 2,
    parameter int NDATA  = 4,
    parameter int CTRL_W = 32
);
    localparam int LANE_W = 1 << (XLEN + 4);
    localparam int DATA_W = NDATA * LANE_W;

    logic              i_clk_en;
    logic              i_flush;
    logic              i_valid_e;
    logic              o_ready_e;
    logic [DATA_W-1:0] i_data_e;
    logic [CTRL_W-1:0] i_ctrl_e;
    logic [3:0]        i_exc_code_e;
    logic              o_valid_m;
    logic              i_ready_m;
    logic [DATA_W-1:0] o_data_m;
    logic [CTRL_W-1:0] o_ctrl_m;
    logic              o_exc_flush;
    logic [3:0]        o_exc_code_q;
    logic [1:0]        o_count;

    modport slave (
        input  i_clk_en, i_flush, i_valid_e, i_data_e, i_ctrl_e, i_exc_code_e, i_ready_m,
        output o_ready_e, o_valid_m, o_data_m, o_ctrl_m, o_exc_flush, o_exc_code_q, o_count
    );

    modport master (
        output i_clk_en, i_flush, i_valid_e, i_data_e, i_ctrl_e, i_exc_code_e, i_ready_m,
        input  o_ready_e, o_valid_m, o_data_m, o_ctrl_m, o_exc_flush, o_exc_code_q, o_count
    );
endinterface

`default_nettype wire

// File: rtl/ex_mem_stage_skid.sv
// ============================================================================
//  Module   : ex_mem_stage_skid
//  Purpose  : Elastic EX/MEM register with 2-entry skid, flush and squash.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module ex_mem_stage_skid #(
    parameter int XLEN   = 2,
    parameter int NDATA  = 4,
    parameter int CTRL_W = 32
) (
    input  wire logic          i_clk,
    input  wire logic          i_rst,
    ex_mem_stage_skid_if.slave bus
);
    localparam int       LANE_W   = 1 << (XLEN + 4);
    localparam int       DATA_W   = NDATA * LANE_W;
    localparam logic [3:0] EXC_NONE = 4'hF;

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_ONE   = 2'd1,
        S_FULL  = 2'd2
    } state_t;

    state_t            state_q;
    logic [DATA_W-1:0] head_data_q;
    logic [CTRL_W-1:0] head_ctrl_q;
    logic [DATA_W-1:0] skid_data_q;
    logic [CTRL_W-1:0] skid_ctrl_q;
    logic [3:0]        exc_code_q;

    logic w_ready;
    logic w_hs;
    logic w_squash;
    logic w_acc;
    logic w_pop;

    // Ready depends only on the skid slot, so memory back-pressure never reaches execute.
    assign w_ready  = (state_q != S_FULL);
    assign w_hs     = bus.i_clk_en & bus.i_valid_e & w_ready;
    assign w_squash = w_hs & ~bus.i_flush & (bus.i_exc_code_e != EXC_NONE);
    assign w_acc    = w_hs & ~bus.i_flush & (bus.i_exc_code_e == EXC_NONE);
    assign w_pop    = bus.i_clk_en & (state_q != S_EMPTY) & bus.i_ready_m;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q     <= S_EMPTY;
            head_data_q <= '0;
            head_ctrl_q <= '0;
            skid_data_q <= '0;
            skid_ctrl_q <= '0;
            exc_code_q  <= EXC_NONE;
        end else if (bus.i_clk_en) begin
            if (bus.i_flush) begin
                state_q     <= S_EMPTY;
                head_data_q <= '0;
                head_ctrl_q <= '0;
                skid_data_q <= '0;
                skid_ctrl_q <= '0;
            end else begin
                if (w_squash) begin
                    exc_code_q <= bus.i_exc_code_e;
                end
                // Empty entries are kept zeroed so the outputs read zero when invalid.
                case (state_q)
                    S_EMPTY: begin
                        if (w_acc) begin
                            head_data_q <= bus.i_data_e;
                            head_ctrl_q <= bus.i_ctrl_e;
                            state_q     <= S_ONE;
                        end
                    end
                    S_ONE: begin
                        if (w_acc && w_pop) begin
                            head_data_q <= bus.i_data_e;
                            head_ctrl_q <= bus.i_ctrl_e;
                        end else if (w_acc) begin
                            skid_data_q <= bus.i_data_e;
                            skid_ctrl_q <= bus.i_ctrl_e;
                            state_q     <= S_FULL;
                        end else if (w_pop) begin
                            head_data_q <= '0;
                            head_ctrl_q <= '0;
                            state_q     <= S_EMPTY;
                        end
                    end
                    S_FULL: begin
                        if (w_pop) begin
                            head_data_q <= skid_data_q;
                            head_ctrl_q <= skid_ctrl_q;
                            skid_data_q <= '0;
                            skid_ctrl_q <= '0;
                            state_q     <= S_ONE;
                        end
                    end
                    default: begin
                        state_q <= S_EMPTY;
                    end
                endcase
            end
        end
    end

    assign bus.o_ready_e    = w_ready;
    assign bus.o_valid_m    = (state_q != S_EMPTY);
    assign bus.o_data_m     = head_data_q;
    assign bus.o_ctrl_m     = head_ctrl_q;
    assign bus.o_exc_flush  = w_squash;
    assign bus.o_exc_code_q = exc_code_q;
    assign bus.o_count      = state_q;

endmodule

`default_nettype wire
